// File: rtl/wb_dac_playback_pkg.sv
// Shared types and Wishbone constants for the DAC playback engine.
package wb_dac_playback_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GAP   = 2'd1,
      ST_FETCH = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam int         BYTES_PER_WORD = 4;
   localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
   localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
   localparam logic [3:0] WB_SEL_ALL     = 4'hF;
endpackage

// File: rtl/wb_dac_playback_fifo.sv
// Synchronous word FIFO with flush; storage is not reset, only pointers and count.
module wb_dac_fifo #(
   parameter int DW = 32,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign full   = (r_count == DEPTH);
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign dout   = r_mem[r_rd];
   assign w_push = push && !full && !flush;
   assign w_pop  = pop && !empty && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= din;
   end
endmodule

// File: rtl/wb_dac_playback.sv
// Wishbone read master that streams packed 32-bit words from memory to an 8-bit DAC
// at a programmable sample rate.
module wb_dac_playback
   import wb_dac_playback_pkg::*;
#(
   parameter int aw      = 32,
   parameter int dw      = 32,
   parameter int dac_dw  = 8,
   parameter int fifo_aw = 3
) (
   input  logic              wb_clk,
   input  logic              wb_rst,
   output logic [aw-1:0]     wb_adr_o,
   output logic [dw-1:0]     wb_dat_o,
   output logic [3:0]        wb_sel_o,
   output logic              wb_we_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic [2:0]        wb_cti_o,
   output logic [1:0]        wb_bte_o,
   input  logic [dw-1:0]     wb_dat_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i,
   input  logic              wb_rty_i,
   input  logic              start,
   input  logic              enable,
   input  logic [aw-1:0]     base_address,
   input  logic [15:0]       word_count,
   input  logic [15:0]       rate_div,
   input  logic              loop,
   output logic [dac_dw-1:0] dac_data,
   output logic              dac_valid,
   output logic              busy,
   output logic              done,
   output logic              underrun,
   output logic              bus_error
);
   state_t            r_state, w_next;
   logic [15:0]       r_idx, r_rate_cnt;
   logic [dw-1:0]     r_hold;
   logic [1:0]        r_byte_idx;
   logic              r_hold_vld;
   logic [dac_dw-1:0] r_dac_data;
   logic              r_dac_valid, r_done, r_underrun, r_bus_error;
   logic              w_flush, w_push, w_pop, w_done, w_launch, w_idx_inc, w_idx_clr, w_err;
   logic              w_last, w_drained, w_room, w_tick, w_tick_ok, w_emit, w_under;
   logic [dw-1:0]     w_fifo_dout;
   logic              w_fifo_full, w_fifo_empty;
   logic [fifo_aw:0]  w_fifo_count;
   logic [aw-3:0]     w_word_adr;
   logic              w_unused;

   wb_dac_fifo #(.DW(dw), .AW(fifo_aw)) u_fifo (
      .clk   (wb_clk),
      .rst   (wb_rst),
      .push  (w_push),
      .pop   (w_pop),
      .flush (w_flush),
      .din   (wb_dat_i),
      .dout  (w_fifo_dout),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .count (w_fifo_count)
   );

   assign w_unused   = ^{base_address[1:0], w_fifo_full};
   assign w_room     = (w_fifo_count < (fifo_aw+1)'(1 << fifo_aw));
   assign w_last     = (r_idx == word_count - 16'd1);
   assign w_drained  = w_fifo_empty && !r_hold_vld;
   assign w_word_adr = base_address[aw-1:2] + (aw-2)'(r_idx);

   always_comb begin
      w_next    = r_state;
      w_flush   = 1'b0;
      w_push    = 1'b0;
      w_done    = 1'b0;
      w_launch  = 1'b0;
      w_idx_inc = 1'b0;
      w_idx_clr = 1'b0;
      w_err     = 1'b0;
      case (r_state)
         ST_IDLE: if (start && enable) begin
            if (word_count != 16'd0) begin
               w_next   = ST_GAP;
               w_launch = 1'b1;
            end else begin
               w_done = 1'b1;
            end
         end
         ST_GAP: begin
            if (!enable) begin
               w_next  = ST_IDLE;
               w_flush = 1'b1;
            end else if (w_room) begin
               w_next = ST_FETCH;
            end
         end
         // the bus cycle always runs to a response, even when aborting
         ST_FETCH: begin
            if (wb_err_i) begin
               w_err   = 1'b1;
               w_flush = 1'b1;
               w_next  = ST_IDLE;
            end else if (!enable) begin
               if (wb_ack_i || wb_rty_i) begin
                  w_flush = 1'b1;
                  w_next  = ST_IDLE;
               end
            end else if (wb_ack_i) begin
               w_push = 1'b1;
               if (w_last && loop) begin
                  w_idx_clr = 1'b1;
                  w_next    = ST_GAP;
               end else begin
                  w_idx_inc = 1'b1;
                  w_next    = w_last ? ST_DRAIN : ST_GAP;
               end
            end else if (wb_rty_i) begin
               w_next = ST_GAP;
            end
         end
         ST_DRAIN: begin
            if (!enable) begin
               w_flush = 1'b1;
               w_next  = ST_IDLE;
            end else if (w_drained) begin
               w_done = 1'b1;
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign w_tick    = (r_state != ST_IDLE) && (r_rate_cnt == rate_div);
   assign w_tick_ok = w_tick && enable && !w_flush;
   assign w_emit    = w_tick_ok && r_hold_vld;
   assign w_under   = w_tick_ok && !r_hold_vld && !((r_state == ST_DRAIN) && w_drained);
   assign w_pop     = !r_hold_vld && !w_fifo_empty && !w_flush;

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_rate_cnt  <= '0;
         r_byte_idx  <= '0;
         r_hold_vld  <= 1'b0;
         r_dac_data  <= '0;
         r_dac_valid <= 1'b0;
         r_done      <= 1'b0;
         r_underrun  <= 1'b0;
         r_bus_error <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_done      <= w_done;
         r_dac_valid <= w_emit;
         if (w_emit) r_dac_data <= r_hold[int'(r_byte_idx)*dac_dw +: dac_dw];
         if (w_launch) begin
            r_underrun  <= 1'b0;
            r_bus_error <= 1'b0;
            r_idx       <= '0;
            r_rate_cnt  <= '0;
         end else begin
            if (w_under) r_underrun  <= 1'b1;
            if (w_err)   r_bus_error <= 1'b1;
            if (w_idx_clr)      r_idx <= '0;
            else if (w_idx_inc) r_idx <= r_idx + 16'd1;
            if (r_state != ST_IDLE) r_rate_cnt <= w_tick ? 16'd0 : r_rate_cnt + 16'd1;
         end
         // unpacker: load a new word only once every byte of the previous one is out
         if (w_flush) begin
            r_hold_vld <= 1'b0;
            r_byte_idx <= '0;
         end else if (w_pop) begin
            r_hold_vld <= 1'b1;
            r_byte_idx <= '0;
         end else if (w_emit) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'(BYTES_PER_WORD - 1)) r_hold_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge wb_clk) begin
      if (w_pop) r_hold <= w_fifo_dout;
   end

   assign wb_cyc_o  = (r_state == ST_FETCH);
   assign wb_stb_o  = wb_cyc_o;
   assign wb_adr_o  = wb_cyc_o ? {w_word_adr, 2'b00} : '0;
   assign wb_dat_o  = '0;
   assign wb_sel_o  = WB_SEL_ALL;
   assign wb_we_o   = 1'b0;
   assign wb_cti_o  = WB_CTI_CLASSIC;
   assign wb_bte_o  = WB_BTE_LINEAR;
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign dac_data  = r_dac_data;
   assign dac_valid = r_dac_valid;
   assign underrun  = r_underrun;
   assign bus_error = r_bus_error;
endmodule

// File: tb/tb_wb_dac_playback.sv
// Scoreboard bench for wb_dac_playback: a negedge memory model answers bus cycles and a
// monitor pops expected samples and bus addresses as the DUT presents them.
module tb_wb_dac_playback;
   logic        wb_clk = 1'b0;
   logic        wb_rst = 1'b1;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;
   logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
   logic        start = 1'b0, enable = 1'b1, loop = 1'b0;
   logic [31:0] base_address = 32'h100;
   logic [15:0] word_count = 16'd0, rate_div = 16'd0;
   logic [7:0]  dac_data;
   logic        dac_valid, busy, done, underrun, bus_error;

   logic [31:0] mem [0:3];
   logic [7:0]  exp_q[$];
   logic [31:0] adr_q[$];
   int ack_delay = 0, rty_at = 0, err_at = 0, read_num = 0, wait_cnt = 0;
   int n_chk = 0, n_fail = 0, done_cnt = 0, cyc_n = 0, last_v = 0, gap_exp = 0;

   always #5 wb_clk = ~wb_clk;
   always @(posedge wb_clk) cyc_n <= cyc_n + 1;

   wb_dac_playback dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
      .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .start(start), .enable(enable),
      .base_address(base_address), .word_count(word_count), .rate_div(rate_div),
      .loop(loop), .dac_data(dac_data), .dac_valid(dac_valid), .busy(busy),
      .done(done), .underrun(underrun), .bus_error(bus_error)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // memory slave: responds after ack_delay wait cycles, checks each issued address
   always @(negedge wb_clk) begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_rty_i = 1'b0;
      if (!wb_rst && wb_cyc_o) begin
         if (wait_cnt < ack_delay) begin
            wait_cnt++;
         end else begin
            wait_cnt = 0;
            read_num++;
            chk("wb_stb", {31'd0, wb_stb_o}, 32'd1);
            if (adr_q.size() > 0) chk("wb_adr", wb_adr_o, adr_q.pop_front());
            if (read_num == err_at)      wb_err_i = 1'b1;
            else if (read_num == rty_at) wb_rty_i = 1'b1;
            else begin
               wb_ack_i = 1'b1;
               wb_dat_i = mem[wb_adr_o[3:2]];
            end
         end
      end else begin
         wait_cnt = 0;
      end
   end

   // sample monitor
   always @(negedge wb_clk) begin
      if (dac_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL dac_unexpected: got %h expected no sample", dac_data);
         end else begin
            chk("dac_data", {24'd0, dac_data}, {24'd0, exp_q.pop_front()});
         end
         if (gap_exp != 0) chk("dac_valid_gap", cyc_n - last_v, gap_exp);
         last_v = cyc_n;
      end
      if (done) done_cnt++;
   end

   task automatic push_bytes(input logic [31:0] w);
      for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
   endtask

   task automatic start_pass(input int wc, input int rd, input logic lp);
      @(negedge wb_clk);
      word_count = 16'(wc);
      rate_div   = 16'(rd);
      loop       = lp;
      read_num   = 0;
      done_cnt   = 0;
      start      = 1'b1;
      @(negedge wb_clk);
      start  = 1'b0;
      last_v = cyc_n;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 2000) begin
         @(negedge wb_clk);
         n++;
      end
      chk(name, {31'd0, busy}, 32'd0);
      repeat (3) @(negedge wb_clk);
   endtask

   initial begin
      mem[0] = 32'h44332211;
      mem[1] = 32'h88776655;
      mem[2] = 32'h0;
      mem[3] = 32'h0;
      repeat (3) @(negedge wb_clk);
      chk("reset_outputs", {busy, wb_cyc_o, wb_stb_o, dac_valid, done, underrun, bus_error, dac_data},
          32'd0);
      wb_rst = 1'b0;
      repeat (2) @(negedge wb_clk);

      // basic two-word pass, sample every 4 cycles
      push_bytes(mem[0]); push_bytes(mem[1]);
      adr_q.push_back(32'h100); adr_q.push_back(32'h104);
      gap_exp = 4;
      start_pass(2, 3, 1'b0);
      wait_idle("basic_busy");
      gap_exp = 0;
      chk("basic_done", done_cnt, 1);
      chk("basic_underrun", {31'd0, underrun}, 32'd0);
      chk("basic_left", exp_q.size(), 0);

      // retry on the first read re-issues the same address
      push_bytes(mem[0]); push_bytes(mem[1]);
      adr_q.push_back(32'h100); adr_q.push_back(32'h100); adr_q.push_back(32'h104);
      rty_at = 1;
      start_pass(2, 3, 1'b0);
      wait_idle("rty_busy");
      rty_at = 0;
      chk("rty_done", done_cnt, 1);
      chk("rty_bus_error", {31'd0, bus_error}, 32'd0);
      chk("rty_left", exp_q.size(), 0);

      // error on the second read: only the byte emitted before it appears
      exp_q.push_back(8'h11);
      adr_q.push_back(32'h100); adr_q.push_back(32'h104);
      ack_delay = 3;
      err_at    = 2;
      start_pass(2, 3, 1'b0);
      wait_idle("err_busy");
      repeat (20) @(negedge wb_clk);
      err_at    = 0;
      ack_delay = 0;
      chk("err_bus_error", {31'd0, bus_error}, 32'd1);
      chk("err_done", done_cnt, 0);
      chk("err_left", exp_q.size(), 0);

      // looping single word, aborted by enable
      mem[0] = 32'hDDCCBBAA;
      for (int i = 0; i < 30; i++) adr_q.push_back(32'h100);
      push_bytes(mem[0]); push_bytes(mem[0]);
      start_pass(1, 3, 1'b1);
      begin
         int n = 0;
         while (exp_q.size() != 0 && n < 500) begin
            @(negedge wb_clk);
            n++;
         end
         chk("loop_samples_seen", exp_q.size(), 0);
      end
      chk("loop_busy_running", {31'd0, busy}, 32'd1);
      enable = 1'b0;
      wait_idle("loop_busy");
      repeat (10) @(negedge wb_clk);
      chk("loop_done", done_cnt, 0);
      chk("loop_bus_error", {31'd0, bus_error}, 32'd0);
      adr_q.delete();
      exp_q.delete();
      enable = 1'b1;
      mem[0] = 32'h44332211;

      // one sample per cycle with slow memory: underrun, data holds the last byte
      push_bytes(mem[0]); push_bytes(mem[1]);
      adr_q.push_back(32'h100); adr_q.push_back(32'h104);
      ack_delay = 6;
      start_pass(2, 0, 1'b0);
      wait_idle("under_busy");
      chk("under_flag", {31'd0, underrun}, 32'd1);
      chk("under_done", done_cnt, 1);
      repeat (5) @(negedge wb_clk);
      chk("under_hold", {24'd0, dac_data}, 32'h88);
      chk("under_left", exp_q.size(), 0);

      // next start clears underrun; reset lands mid-FETCH
      start_pass(2, 3, 1'b0);
      chk("start_clears_underrun", {31'd0, underrun}, 32'd0);
      begin
         int n = 0;
         while (!wb_cyc_o && n < 50) begin
            @(negedge wb_clk);
            n++;
         end
         chk("rst_cyc_seen", {31'd0, wb_cyc_o}, 32'd1);
      end
      @(negedge wb_clk);
      #2 wb_rst = 1'b1;
      #1 chk("rst_async_outs", {28'd0, wb_cyc_o, wb_stb_o, busy, dac_valid}, 32'd0);
      @(negedge wb_clk);
      #2 wb_rst = 1'b0;
      ack_delay = 0;
      repeat (2) @(negedge wb_clk);
      push_bytes(mem[0]); push_bytes(mem[1]);
      adr_q.push_back(32'h100); adr_q.push_back(32'h104);
      start_pass(2, 3, 1'b0);
      wait_idle("restart_busy");
      chk("restart_done", done_cnt, 1);
      chk("restart_left", exp_q.size(), 0);

      // zero-length pass: done next cycle without going busy
      start_pass(0, 3, 1'b0);
      chk("zero_done_pulse", {30'd0, done, busy}, 32'h2);
      repeat (3) @(negedge wb_clk);
      chk("zero_done_cnt", done_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
